// File: rtl/delay_pkg.sv
// Shared types for the multi-channel programmable delay timer.
// Channel state and run mode encodings used by delay_chan and its testbench.
package delay_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chan_state_e;

   typedef enum logic {
      PERIODIC = 1'b0,
      ONESHOT  = 1'b1
   } mode_e;

endpackage

// File: rtl/delay_chan.sv
// One timer channel: counts enabled cycles up to a loadable period and
// emits a registered one-cycle sig pulse; periodic or one-shot.
module delay_chan
   import delay_pkg::*;
#(
   parameter int CBITS     = 12,
   parameter int DEFAULT_N = 2500
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ld,
   input  logic [CBITS-1:0] ld_period,
   input  logic             ld_mode,
   output logic             sig,
   output logic             flg,
   output logic             err,
   output logic             busy
);

   logic [CBITS-1:0] per_q;
   logic [CBITS-1:0] cnt;
   mode_e            mode_q;
   chan_state_e      state;

   // NOTE: every register here uses non-blocking assignments so each branch
   // reads the pre-edge values of cnt/state, never a half-updated mix.
   always_ff @(posedge clk) begin
      if (rst) begin
         per_q  <= CBITS'(DEFAULT_N);
         mode_q <= PERIODIC;
         cnt    <= '0;
         state  <= IDLE;
         sig    <= 1'b0;
      end else if (ld) begin
         // A load aborts any count in progress; en must be re-sampled in IDLE.
         per_q  <= ld_period;
         mode_q <= mode_e'(ld_mode);
         cnt    <= '0;
         state  <= IDLE;
         sig    <= 1'b0;
      end else begin
         sig <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  state <= RUN;
                  cnt   <= '0;
               end
            end
            RUN: begin
               if (!en) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == per_q) begin
                  sig <= 1'b1;
                  cnt <= '0;
                  if (mode_q == ONESHOT) state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               cnt <= '0;
               if (!en) state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // cnt is bounded by per_q on every path, so err is a pure safety monitor.
   assign flg  = (cnt <= per_q);
   assign err  = (cnt > per_q);
   assign busy = (state == RUN);

endmodule

// File: rtl/multi_delay_timer.sv
// NCH independent delay_chan instances sharing one load port; ld_ch values
// at or above NCH select no channel.
module multi_delay_timer
   import delay_pkg::*;
#(
   parameter int  NCH       = 4,
   parameter int  CBITS     = 12,
   parameter int  DEFAULT_N = 2500,
   localparam int LCW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en,
   input  logic             ld_valid,
   input  logic [LCW-1:0]   ld_ch,
   input  logic [CBITS-1:0] ld_period,
   input  logic             ld_mode,
   output logic [NCH-1:0]   sig,
   output logic [NCH-1:0]   flg,
   output logic [NCH-1:0]   err,
   output logic [NCH-1:0]   busy
);

   logic [NCH-1:0] ld_hit;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign ld_hit[i] = ld_valid && (ld_ch == LCW'(i));

      delay_chan #(
         .CBITS     (CBITS),
         .DEFAULT_N (DEFAULT_N)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .en        (en[i]),
         .ld        (ld_hit[i]),
         .ld_period (ld_period),
         .ld_mode   (ld_mode),
         .sig       (sig[i]),
         .flg       (flg[i]),
         .err       (err[i]),
         .busy      (busy[i])
      );
   end

endmodule

// File: tb/tb_multi_delay_timer.sv
// Self-checking bench for multi_delay_timer: directed scenarios plus random
// stress, all compared against an elapsed-time reference model.
module tb_multi_delay_timer;

   localparam int NCH       = 5;
   localparam int CBITS     = 12;
   localparam int DEFAULT_N = 2500;
   localparam int LCW       = 3;
   localparam logic [NCH-1:0] ALL1 = '1;
   localparam logic [NCH-1:0] ALL0 = '0;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NCH-1:0]   en = '0;
   logic             ld_valid = 1'b0;
   logic [LCW-1:0]   ld_ch = '0;
   logic [CBITS-1:0] ld_period = '0;
   logic             ld_mode = 1'b0;
   logic [NCH-1:0]   sig, flg, err, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: elapsed enabled cycles since the run started; a pulse
   // falls on every multiple of P+1, and a one-shot is silenced after one.
   int             m_per   [NCH];
   bit             m_one   [NCH];
   bit             m_run   [NCH];
   bit             m_fired [NCH];
   int             m_t     [NCH];
   logic [NCH-1:0] m_sig  = '0;
   logic [NCH-1:0] m_busy = '0;

   multi_delay_timer #(
      .NCH       (NCH),
      .CBITS     (CBITS),
      .DEFAULT_N (DEFAULT_N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .ld_valid  (ld_valid),
      .ld_ch     (ld_ch),
      .ld_period (ld_period),
      .ld_mode   (ld_mode),
      .sig       (sig),
      .flg       (flg),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      for (int i = 0; i < NCH; i++) begin
         if (rst) begin
            m_per[i] = DEFAULT_N; m_one[i] = 1'b0; m_run[i] = 1'b0;
            m_fired[i] = 1'b0; m_t[i] = 0; m_sig[i] = 1'b0;
         end else if (ld_valid && int'(ld_ch) == i) begin
            m_per[i] = int'(ld_period); m_one[i] = ld_mode; m_run[i] = 1'b0;
            m_fired[i] = 1'b0; m_sig[i] = 1'b0;
         end else if (!en[i]) begin
            m_run[i] = 1'b0; m_fired[i] = 1'b0; m_sig[i] = 1'b0;
         end else if (!m_run[i]) begin
            m_run[i] = 1'b1; m_t[i] = 0; m_sig[i] = 1'b0;
         end else begin
            m_t[i]++;
            m_sig[i] = !m_fired[i] && (m_t[i] % (m_per[i] + 1) == 0);
            if (m_sig[i] && m_one[i]) m_fired[i] = 1'b1;
         end
         m_busy[i] = m_run[i] && !m_fired[i];
      end
      #1;
      cyc++;
   endtask

   task automatic load(input int ch, input int p, input bit mode);
      ld_valid  = 1'b1;
      ld_ch     = LCW'(ch);
      ld_period = CBITS'(p);
      ld_mode   = mode;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (sig !== ALL0 || flg !== ALL1 || err !== ALL0 || busy !== ALL0) begin
         errors++;
         $display("FAIL reset: sig %b flg %b err %b busy %b, need 0/all1/0/0", sig, flg, err, busy);
      end
   endtask

   task automatic test_default_period();
      int first = -1, prev = -1, npulse = 0, bad_gap = 0;
      en[0] = 1'b1;
      for (int n = 1; n <= 7600; n++) begin
         step();
         checks++;
         if (sig !== m_sig || busy !== m_busy || flg !== ALL1 || err !== ALL0) begin
            errors++;
            $display("FAIL default cyc %0d: sig %b exp %b busy %b exp %b flg %b err %b", cyc, sig, m_sig, busy, m_busy, flg, err);
         end
         if (sig[0]) begin
            if (first < 0) first = n;
            if (prev >= 0 && n - prev != 2501) bad_gap++;
            prev = n;
            npulse++;
         end
      end
      checks++;
      if (first - 1 != 2501 || npulse != 3 || bad_gap != 0) begin
         errors++;
         $display("FAIL default_timing: first %0d count %0d badgaps %0d, need 2501/3/0", first - 1, npulse, bad_gap);
      end
      en[0] = 1'b0;
      step();
   endtask

   task automatic test_oneshot();
      int first = -1, npulse = 0;
      load(1, 3, 1'b1);
      step();
      ld_valid = 1'b0;
      en[1] = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         step();
         checks++;
         if (sig !== m_sig || busy !== m_busy || flg !== ALL1 || err !== ALL0) begin
            errors++;
            $display("FAIL oneshot cyc %0d: sig %b exp %b busy %b exp %b flg %b err %b", cyc, sig, m_sig, busy, m_busy, flg, err);
         end
         if (sig[1]) begin
            if (first < 0) first = n;
            npulse++;
         end
      end
      checks++;
      if (first - 1 != 4 || npulse != 1 || busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_first: delay %0d count %0d busy %b, need 4/1/0", first - 1, npulse, busy[1]);
      end
      en[1] = 1'b0;
      step();
      en[1] = 1'b1;
      npulse = 0;
      for (int n = 1; n <= 12; n++) begin
         step();
         if (sig[1]) npulse++;
      end
      checks++;
      if (npulse != 1) begin
         errors++;
         $display("FAIL oneshot_rearm: count %0d, need 1", npulse);
      end
      en[1] = 1'b0;
      step();
   endtask

   task automatic test_p0();
      int npulse = 0;
      load(2, 0, 1'b0);
      step();
      ld_valid = 1'b0;
      en[2] = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         step();
         checks++;
         if (sig !== m_sig || busy !== m_busy || flg !== ALL1 || err !== ALL0) begin
            errors++;
            $display("FAIL p0 cyc %0d: sig %b exp %b busy %b exp %b flg %b err %b", cyc, sig, m_sig, busy, m_busy, flg, err);
         end
         if (sig[2]) npulse++;
      end
      checks++;
      if (npulse != 7 || sig[1:0] !== 2'b00 || sig[4:3] !== 2'b00) begin
         errors++;
         $display("FAIL p0_count: count %0d others %b, need 7 and quiet", npulse, {sig[4:3], sig[1:0]});
      end
   endtask

   task automatic test_reload();
      int first = -1;
      load(0, 10, 1'b0);
      step();
      ld_valid = 1'b0;
      en[0] = 1'b1;
      for (int n = 0; n < 8; n++) step();
      load(0, 5, 1'b0);
      step();
      ld_valid = 1'b0;
      checks++;
      if (sig[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL reload_abort: sig %b busy %b, need 0/0", sig[0], busy[0]);
      end
      for (int j = 1; j <= 10; j++) begin
         step();
         checks++;
         if (sig !== m_sig || busy !== m_busy || flg !== ALL1 || err !== ALL0) begin
            errors++;
            $display("FAIL reload cyc %0d: sig %b exp %b busy %b exp %b flg %b err %b", cyc, sig, m_sig, busy, m_busy, flg, err);
         end
         if (sig[0] && first < 0) first = j;
      end
      checks++;
      if (first != 7) begin
         errors++;
         $display("FAIL reload_delay: first pulse %0d after load, need 7", first);
      end
   endtask

   task automatic test_stop_and_reset();
      load(3, 4, 1'b0);
      step();
      ld_valid = 1'b0;
      en[3] = 1'b1;
      for (int n = 0; n < 5; n++) step();
      en[3] = 1'b0;
      step();
      checks++;
      if (sig[3] !== 1'b0 || busy[3] !== 1'b0 || sig !== m_sig) begin
         errors++;
         $display("FAIL stop_wins: sig %b busy %b, need 0/0", sig[3], busy[3]);
      end
      en = '1;
      for (int n = 0; n < 6; n++) step();
      rst = 1'b1;
      step();
      checks++;
      if (sig !== ALL0 || flg !== ALL1 || err !== ALL0 || busy !== ALL0) begin
         errors++;
         $display("FAIL mid_reset: sig %b flg %b err %b busy %b, need 0/all1/0/0", sig, flg, err, busy);
      end
      rst = 1'b0;
      en = '0;
      step();
   endtask

   task automatic test_bad_channel();
      load(1, 2, 1'b0);
      step();
      load(4, 3, 1'b0);
      step();
      ld_valid = 1'b0;
      en = 5'b10010;
      for (int n = 0; n < 3; n++) step();
      for (int c = NCH; c < 8; c++) begin
         load(c, 0, 1'b1);
         step();
      end
      ld_valid = 1'b0;
      for (int n = 0; n < 20; n++) begin
         step();
         checks++;
         if (sig !== m_sig || busy !== m_busy || flg !== ALL1 || err !== ALL0) begin
            errors++;
            $display("FAIL bad_ch cyc %0d: sig %b exp %b busy %b exp %b flg %b err %b", cyc, sig, m_sig, busy, m_busy, flg, err);
         end
      end
      en = '0;
      step();
   endtask

   task automatic test_max_period();
      int first = -1;
      load(4, 4095, 1'b0);
      step();
      ld_valid = 1'b0;
      en[4] = 1'b1;
      for (int n = 1; n <= 4100; n++) begin
         step();
         if (sig[4] && first < 0) first = n;
      end
      checks++;
      if (first - 1 != 4096 || err !== ALL0) begin
         errors++;
         $display("FAIL max_period: delay %0d err %b, need 4096/0", first - 1, err);
      end
      en[4] = 1'b0;
      step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(7, 0) == 0) en[$urandom_range(NCH - 1, 0)] ^= 1'b1;
         if ($urandom_range(9, 0) == 0)
            load($urandom_range(7, 0), $urandom_range(11, 0), 1'($urandom_range(1, 0)));
         else
            ld_valid = 1'b0;
         step();
         checks++;
         if (sig !== m_sig || busy !== m_busy || flg !== ALL1 || err !== ALL0) begin
            errors++;
            $display("FAIL random cyc %0d: sig %b exp %b busy %b exp %b flg %b err %b", cyc, sig, m_sig, busy, m_busy, flg, err);
         end
      end
      ld_valid = 1'b0;
      en = '0;
   endtask

   initial begin
      test_reset();
      test_default_period();
      test_oneshot();
      test_p0();
      test_reload();
      test_stop_and_reset();
      test_bad_channel();
      test_max_period();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_delay_timer.md
# multi_delay_timer

Parametrised, multi-channel programmable delay timer. Each of `NCH` independent channels counts clock cycles up to a runtime-loadable period and emits a one-cycle `sig` pulse. Each channel runs periodic or one-shot. The block carries over the single-channel fixed-N delay counter's `sig`/`flg`/`err` observables per channel, so the same liveness and safety properties apply channel-wise. It sits beside control FSMs as a shared timeout/tick source and as a formal benchmark target.

## Interface
Parameters:
- `NCH`, default 4: number of channels, ≥1.
- `CBITS`, default 12: counter and period width.
- `DEFAULT_N`, default 2500: period loaded at reset, < 2^CBITS.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high. Clock is `clk`.
- `en`, input, NCH: per-channel run enable, level-sensitive.
- `ld_valid`, input, 1: load strobe, one channel per cycle.
- `ld_ch`, input, $clog2(NCH) (min 1): target channel of the load.
- `ld_period`, input, CBITS: new period P.
- `ld_mode`, input, 1: 0 = periodic, 1 = one-shot.
- `sig`, output, NCH: registered one-cycle expiry pulse.
- `flg`, output, NCH: `cnt <= per_q`, combinational from registers.
- `err`, output, NCH: `cnt > per_q`, combinational from registers. Must never assert.
- `busy`, output, NCH: channel state is RUN.

## Operation
- Per-channel registers: `per_q` (CBITS), `mode_q`, `cnt` (CBITS), `state` ∈ {IDLE, RUN, DONE}, `sig`.
- On reset: `per_q`=DEFAULT_N, `mode_q`=periodic, `cnt`=0, `state`=IDLE. Outputs after reset: `sig`=0, `flg`=1, `err`=0, `busy`=0.
- Priority per channel each cycle is `rst` > load hit > state logic. A load hit is `ld_valid && ld_ch==i`.
- Load hit: `per_q`←`ld_period`, `mode_q`←`ld_mode`, `cnt`←0, `state`←IDLE, `sig`←0. This happens even if the channel is running, which aborts the current count.
- `ld_ch` ≥ NCH: the load is ignored and no channel changes.
- IDLE: if `en[i]`, go to RUN with `cnt`←0. Otherwise hold.
- RUN:
  - `!en[i]`: go to IDLE, `cnt`←0, no pulse.
  - `en[i]` and `cnt==per_q`: `sig`←1, `cnt`←0. In one-shot mode, go to DONE. In periodic mode, stay in RUN.
  - Otherwise: `cnt`←`cnt`+1.
- DONE: `cnt` holds 0. When `en[i]` drops, go to IDLE. One-shot never re-fires without an `en` low/high cycle.
- `sig` is 0 in every cycle not listed above, so it is never high two cycles in a row unless P=0 in periodic mode.
- Counter arithmetic is unsigned CBITS. `cnt` never exceeds `per_q`, so no wrap occurs. P=2^CBITS−1 is legal.
- Channels are fully independent. Simultaneous expiry on several channels gives simultaneous pulses.

## Timing
- `en[i]` is first sampled high at edge k in IDLE. The first `sig[i]` is high in the cycle after edge k+P+1. Subsequent periodic pulses follow every P+1 cycles.
- P=0 in periodic mode: `sig` is high every cycle starting after edge k+1. In one-shot mode it gives a single pulse.
- A load takes effect at the next edge. `en` held high across a load restarts the count in the cycle after the load (IDLE→RUN), so the first post-load pulse is at load edge + P+2.
- `en` deasserted on the same edge where `cnt==per_q` suppresses the pulse: stop wins.
- Properties per channel:
  - always `err==0`.
  - if `rst` is eventually low forever and `en[i]` is eventually high forever in periodic mode, then eventually always (`flg` s_until `sig`).

## Structure
- Package `delay_pkg`: `chan_state_e` {IDLE, RUN, DONE}, `mode_e` {PERIODIC, ONESHOT}.
- Sub-module `delay_chan`: one channel (params CBITS, DEFAULT_N; ports clk, rst, en, ld, ld_period, ld_mode, sig, flg, err, busy).
- Top `multi_delay_timer`: generate-loop over `NCH` `delay_chan` instances, plus `ld_ch` decode.

## Test plan
- Reset then `en[0]`=1 with DEFAULT_N=2500 → `sig[0]` pulses 2501 cycles after the enable edge, and every 2501 cycles after that. `flg[0]`=1 and `err`=0 throughout.
- Load ch1 P=3 one-shot, then `en[1]`=1 → one pulse 4 cycles after the enable edge, `busy[1]` drops, no further pulse. `en[1]` low then high → one new pulse.
- Load ch2 P=0 periodic, `en[2]`=1 → `sig[2]` high every cycle. Other channels unaffected.
- Ch0 running at P=10, load P=5 at `cnt`=7 with `en` held high → no pulse. The next pulse arrives 7 cycles after the load edge.
- Drop `en[3]` on the same edge `cnt==per_q` → no pulse, `cnt`=0, `busy[3]`=0. Assert `rst` mid-count on all channels → all outputs at reset values the next cycle.
- `ld_valid` with `ld_ch`=NCH (when NCH is not a power of two) → no channel state change. Random en/load stress → `err` never asserts.
